// File: rtl/bus_defs.sv
// rtl/bus_defs.sv - shared widths, reset value and named register indices for the register bank
package bus_defs;

    localparam int BUS_WIDTH     = 16;
    localparam int BUS_SEL_W     = 3;
    localparam int BUS_RESET_VAL = 0;

    // Register roles the control unit relies on when addressing the bank
    typedef enum logic [BUS_SEL_W-1:0] {
        R_SP = 3'd6,
        R_PC = 3'd7
    } reg_idx_e;

endpackage

// File: rtl/bus_reg_file_if.sv
// rtl/bus_reg_file_if.sv - control-side select/enable bundle between control unit and register bank
interface bus_reg_file_if #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
);

    logic             in_en;
    logic [SEL_W-1:0] in_sel;
    logic             out_en;
    logic [SEL_W-1:0] out_sel;
    logic             step_en;
    logic [SEL_W-1:0] step_sel;
    logic             step_dn;
    logic             wrap;
    logic [SEL_W-1:0] dbg_sel;
    logic [WIDTH-1:0] dbg_data;

    modport master (
        output in_en, in_sel, out_en, out_sel,
        output step_en, step_sel, step_dn, dbg_sel,
        input  wrap, dbg_data
    );

    modport slave (
        input  in_en, in_sel, out_en, out_sel,
        input  step_en, step_sel, step_dn, dbg_sel,
        output wrap, dbg_data
    );

endinterface

// File: rtl/bus_reg_file_cell.sv
// rtl/bus_reg_file_cell.sv - one bank register with load, +/-1 step, zero hardwire and wrap pulse
module bus_reg_cell #(
    parameter int               WIDTH     = 16,
    parameter bit               ZERO      = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             step,
    input  logic             step_dn,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= ZERO ? '0 : RESET_VAL;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (ZERO) begin
                q <= '0;
            end else if (load) begin
                // a load on the same edge discards the step and its wrap
                q <= d;
            end else if (step) begin
                q    <= step_dn ? q - 1'b1 : q + 1'b1;
                wrap <= step_dn ? (q == '0) : (q == '1);
            end
        end
    end

endmodule

// File: rtl/bus_reg_file.sv
// rtl/bus_reg_file.sv - bank of general registers sharing the tri-state system data bus
module bus_reg_file
    import bus_defs::*;
#(
    parameter int               WIDTH     = BUS_WIDTH,
    parameter int               NUM_REGS  = 8,
    parameter int               SEL_W     = BUS_SEL_W,
    parameter bit               ZERO_R0   = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(BUS_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] bus,
    bus_reg_file_if.slave    bif
);

    logic [WIDTH-1:0]    q [NUM_REGS];
    logic [NUM_REGS-1:0] wrap_v;
    logic [WIDTH-1:0]    out_data;
    logic [WIDTH-1:0]    dbg_data;
    logic                out_hit;
    logic                drive;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        bus_reg_cell #(
            .WIDTH     (WIDTH),
            .ZERO      (ZERO_R0 && (i == 0)),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .load    (bif.in_en && (bif.in_sel == SEL_W'(i))),
            .d       (bus),
            .step    (bif.step_en && (bif.step_sel == SEL_W'(i))),
            .step_dn (bif.step_dn),
            .q       (q[i]),
            .wrap    (wrap_v[i])
        );
    end

    // Selects beyond NUM_REGS match no cell, so they read 0 and never drive
    always_comb begin
        out_data = '0;
        dbg_data = '0;
        out_hit  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bif.out_sel == SEL_W'(i)) begin
                out_data = q[i];
                out_hit  = 1'b1;
            end
            if (bif.dbg_sel == SEL_W'(i)) begin
                dbg_data = q[i];
            end
        end
    end

    assign drive        = bif.out_en && !rst && out_hit;
    assign bus          = drive ? out_data : {WIDTH{1'bz}};
    assign bif.dbg_data = dbg_data;
    assign bif.wrap     = |wrap_v;

endmodule

// File: tb/tb_bus_reg_file.sv
// tb/tb_bus_reg_file.sv - directed self-checking bench for bus_reg_file (normal and zero-r0 banks)
module tb_bus_reg_file;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    wire  [15:0] bus_a;
    wire  [15:0] bus_z;
    logic        drv_a;
    logic [15:0] val_a;
    logic        drv_z;
    logic [15:0] val_z;

    assign bus_a = drv_a ? val_a : 16'hzzzz;
    assign bus_z = drv_z ? val_z : 16'hzzzz;

    bus_reg_file_if #(.WIDTH(16), .SEL_W(3)) bif_a ();
    bus_reg_file_if #(.WIDTH(16), .SEL_W(3)) bif_z ();

    bus_reg_file #(.WIDTH(16), .NUM_REGS(8), .SEL_W(3), .ZERO_R0(1'b0), .RESET_VAL(16'h0000)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a),
        .bif (bif_a.slave)
    );

    bus_reg_file #(.WIDTH(16), .NUM_REGS(6), .SEL_W(3), .ZERO_R0(1'b1), .RESET_VAL(16'h0000)) u_z (
        .clk (clk),
        .rst (rst),
        .bus (bus_z),
        .bif (bif_z.slave)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bif_a.in_en)
            assert (drv_a || bif_a.out_en)
            else begin failures++; $error("FAIL undriven_load_a: in_en=1 with nobody driving bus"); end
        if (!rst && bif_z.in_en)
            assert (drv_z || bif_z.out_en)
            else begin failures++; $error("FAIL undriven_load_z: in_en=1 with nobody driving bus"); end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin failures++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp); end
    endtask

    task automatic dbg_a(input string tag, input logic [2:0] sel, input logic [15:0] exp);
        bif_a.dbg_sel = sel;
        #1;
        chk(tag, bif_a.dbg_data, exp);
    endtask

    task automatic dbg_z(input string tag, input logic [2:0] sel, input logic [15:0] exp);
        bif_z.dbg_sel = sel;
        #1;
        chk(tag, bif_z.dbg_data, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drv_a = 1'b0; val_a = '0; drv_z = 1'b0; val_z = '0;
        bif_a.in_en = 0; bif_a.in_sel = 0; bif_a.out_en = 1; bif_a.out_sel = 3'd2;
        bif_a.step_en = 0; bif_a.step_sel = 0; bif_a.step_dn = 0; bif_a.dbg_sel = 0;
        bif_z.in_en = 0; bif_z.in_sel = 0; bif_z.out_en = 0; bif_z.out_sel = 0;
        bif_z.step_en = 0; bif_z.step_sel = 0; bif_z.step_dn = 0; bif_z.dbg_sel = 0;
        rst = 1'b1;

        // Reset holds the bus released even with a drive request
        #3;
        checks++;
        assert (bus_a === 16'hzzzz)
        else begin failures++; $error("FAIL rst_bus_release observed=%h expected=zzzz", bus_a); end
        chk("rst_wrap", {15'd0, bif_a.wrap}, 16'd0);
        tick;
        tick;
        rst = 1'b0;
        bif_a.out_en = 0;
        for (int i = 0; i < 8; i++) dbg_a($sformatf("rst_reg%0d", i), 3'(i), 16'h0000);

        // Load from an external agent, then drive the same register back
        drv_a = 1; val_a = 16'hA5C3; bif_a.in_en = 1; bif_a.in_sel = 3'd3;
        tick;
        drv_a = 0; bif_a.in_en = 0; bif_a.out_en = 1; bif_a.out_sel = 3'd3;
        #1;
        chk("drive_reg3", bus_a, 16'hA5C3);
        bif_a.out_en = 0;
        #1;
        checks++;
        assert (bus_a === 16'hzzzz)
        else begin failures++; $error("FAIL release_bus observed=%h expected=zzzz", bus_a); end

        // Drive and load on the same register keeps its value
        bif_a.out_en = 1; bif_a.in_en = 1;
        tick;
        bif_a.out_en = 0; bif_a.in_en = 0;
        dbg_a("drive_load_same", 3'd3, 16'hA5C3);

        // Step wrap in both directions
        drv_a = 1; val_a = 16'hFFFF; bif_a.in_en = 1; bif_a.in_sel = 3'd5;
        tick;
        drv_a = 0; bif_a.in_en = 0;
        bif_a.step_en = 1; bif_a.step_sel = 3'd5; bif_a.step_dn = 0;
        tick;
        bif_a.step_en = 0;
        dbg_a("inc_wrap_val", 3'd5, 16'h0000);
        chk("inc_wrap_pulse", {15'd0, bif_a.wrap}, 16'd1);
        tick;
        chk("inc_wrap_clear", {15'd0, bif_a.wrap}, 16'd0);
        bif_a.step_en = 1; bif_a.step_dn = 1;
        tick;
        bif_a.step_en = 0;
        dbg_a("dec_wrap_val", 3'd5, 16'hFFFF);
        chk("dec_wrap_pulse", {15'd0, bif_a.wrap}, 16'd1);
        bif_a.step_en = 1;
        tick;
        bif_a.step_en = 0;
        dbg_a("dec_nowrap_val", 3'd5, 16'hFFFE);
        chk("dec_nowrap_pulse", {15'd0, bif_a.wrap}, 16'd0);

        // Drive and step on the same register: bus shows pre-step value
        bif_a.out_en = 1; bif_a.out_sel = 3'd5; bif_a.step_en = 1; bif_a.step_dn = 0;
        #1;
        chk("drive_step_pre", bus_a, 16'hFFFE);
        tick;
        bif_a.step_en = 0;
        #1;
        chk("drive_step_post", bus_a, 16'hFFFF);
        chk("drive_step_wrap", {15'd0, bif_a.wrap}, 16'd0);
        bif_a.out_en = 0;

        // Load and step collide on one register: load wins
        drv_a = 1; val_a = 16'h0010; bif_a.in_en = 1; bif_a.in_sel = 3'd2;
        tick;
        val_a = 16'h1234; bif_a.step_en = 1; bif_a.step_sel = 3'd2; bif_a.step_dn = 0;
        tick;
        bif_a.in_en = 0; bif_a.step_en = 0;
        dbg_a("collide_same_val", 3'd2, 16'h1234);
        chk("collide_same_wrap", {15'd0, bif_a.wrap}, 16'd0);
        val_a = 16'h0007; bif_a.in_en = 1; bif_a.in_sel = 3'd4;
        tick;
        val_a = 16'h1234; bif_a.in_sel = 3'd2; bif_a.step_en = 1; bif_a.step_sel = 3'd4;
        tick;
        drv_a = 0; bif_a.in_en = 0; bif_a.step_en = 0;
        dbg_a("collide_diff_r2", 3'd2, 16'h1234);
        dbg_a("collide_diff_r4", 3'd4, 16'h0008);

        // Asynchronous reset between edges overrides an in-flight load
        drv_a = 1; val_a = 16'h1111; bif_a.in_en = 1; bif_a.in_sel = 3'd1;
        tick;
        val_a = 16'h5555;
        dbg_a("pre_rst_reg1", 3'd1, 16'h1111);
        #5;
        rst = 1'b1;
        #1;
        dbg_a("mid_rst_reg1", 3'd1, 16'h0000);
        dbg_a("mid_rst_reg3", 3'd3, 16'h0000);
        tick;
        dbg_a("held_rst_reg1", 3'd1, 16'h0000);
        drv_a = 0; bif_a.in_en = 0;
        rst = 1'b0;
        tick;

        // Zero-hardwired register 0 and out-of-range selects
        drv_z = 1; val_z = 16'hBEEF; bif_z.in_en = 1; bif_z.in_sel = 3'd0;
        tick;
        bif_z.in_sel = 3'd1;
        tick;
        drv_z = 0; bif_z.in_en = 0;
        dbg_z("z_load_r0", 3'd0, 16'h0000);
        dbg_z("z_load_r1", 3'd1, 16'hBEEF);
        bif_z.step_en = 1; bif_z.step_sel = 3'd0; bif_z.step_dn = 1;
        tick;
        bif_z.step_en = 0;
        dbg_z("z_step_r0", 3'd0, 16'h0000);
        chk("z_step_wrap", {15'd0, bif_z.wrap}, 16'd0);
        bif_z.out_en = 1; bif_z.out_sel = 3'd0;
        #1;
        checks++;
        assert (bus_z === 16'h0000)
        else begin failures++; $error("FAIL z_drive_r0 observed=%h expected=0000", bus_z); end
        bif_z.out_sel = 3'd1;
        #1;
        chk("z_drive_r1", bus_z, 16'hBEEF);
        bif_z.out_sel = 3'd6;
        #1;
        checks++;
        assert (bus_z === 16'hzzzz)
        else begin failures++; $error("FAIL z_oor_release observed=%h expected=zzzz", bus_z); end
        bif_z.out_en = 0;
        dbg_z("z_oor_dbg", 3'd7, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_reg_file.md
Name: bus_reg_file

Overview:
- Parametrised bank of NUM_REGS general registers sharing the processor's single tri-state data bus; replaces per-register instances in the datapath.
- Each cycle the bank can load one register from the bus and drive one register onto the bus.
- It can also step one register (+1/-1) for PC/SP-style use, and optionally hardwire register 0 to zero.
- Sits between the control unit, which supplies selects and enables, and the shared bus.

Parameters:
- WIDTH, 16, data/register width in bits
- NUM_REGS, 8, number of registers (2..16)
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_REGS
- ZERO_R0, 0, 1 = register 0 reads as 0 and ignores load/step
- RESET_VAL, 0, value of every register after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- bus  inout  WIDTH  shared system data bus
- in_en  in  1  load enable: capture bus into register in_sel
- in_sel  in  SEL_W  register to load
- out_en  in  1  drive enable: place register out_sel on bus
- out_sel  in  SEL_W  register to drive
- step_en  in  1  step enable for register step_sel
- step_sel  in  SEL_W  register to step
- step_dn  in  1  0 = increment, 1 = decrement
- wrap  out  1  registered; high for one cycle after a step that wrapped
- dbg_sel  in  SEL_W  debug read select
- dbg_data  out  WIDTH  combinational debug view of register dbg_sel

Behaviour:
- Reset: already decided — reset rst, asynchronous, active-high; clock clk.
  - All registers go to RESET_VAL (register 0 reads 0 when ZERO_R0=1) and wrap goes to 0.
  - bus is released (all bits z) while rst is high, regardless of out_en.
  - Deassertion takes effect at the next rising edge.
- Drive:
  - bus = reg[out_sel] combinationally whenever out_en=1, rst=0 and out_sel < NUM_REGS.
  - Otherwise bus is all z. No latency.
- Load: at a rising edge with in_en=1 and in_sel < NUM_REGS, reg[in_sel] <= bus. Result is visible on the drive and debug paths in the next cycle.
- Step:
  - At a rising edge with step_en=1 and step_sel < NUM_REGS, reg[step_sel] <= reg[step_sel] ± 1, modulo 2**WIDTH.
  - Wrap-around: all-ones +1 gives 0; 0 -1 gives all-ones. Either case sets wrap=1 in the following cycle only.
- Simultaneous events:
  - Load and step on the same register: load wins, step is discarded, wrap=0.
  - Load and step on different registers: both occur.
  - Drive and load on the same register: register retains its value (bus carries that value); this is legal.
  - Drive and step on the same register: bus shows the pre-step value; the new value is visible next cycle.
- ZERO_R0=1: loads and steps to register 0 are ignored (wrap stays 0); driving register 0 puts 0 on the bus; dbg_data reads 0.
- Out-of-range selects (sel >= NUM_REGS): load and step are no-ops; drive releases the bus; dbg_data = 0.
- Loading while no agent drives the bus is a control-unit error. Bench assertions flag in_en=1 with bus containing z/x.
- dbg_data = reg[dbg_sel] combinationally, with no effect on state.
- Reset mid-operation overrides any in-flight load or step; no partial update is visible after reset.

Decomposition:
- Shared include/package bus_defs: default WIDTH (16), default SEL_W, RESET_VAL, and named register indices (R_PC, R_SP) used by the control unit.
- One natural sub-module: bus_reg_cell.
  - Single WIDTH register with load, step/direction, zero-hardwire option and a wrap pulse output.
  - Instantiated NUM_REGS times.
- Decoding, tri-state driver, debug mux and OR-reduction of the wrap pulses stay in bus_reg_file.

Test Plan:
- Reset: rst=1 with out_en=1, out_sel=2 -> bus = z; after release, dbg_sel=0..7 -> all read 0x0000, wrap=0.
- Load/drive: external agent drives 0xA5C3, in_en=1, in_sel=3, one edge; then agent releases, out_en=1, out_sel=3 -> bus = 0xA5C3 in the same cycle.
- Step wrap: load reg5=0xFFFF; step_en=1, step_sel=5, step_dn=0 -> reg5=0x0000 and wrap=1 for exactly one cycle. Then step_dn=1 -> reg5=0xFFFF and wrap pulses again.
- Collision: reg2=0x0010; same edge in_en=1, in_sel=2, bus=0x1234, step_en=1, step_sel=2 -> reg2=0x1234, wrap=0. Repeat with step_sel=4 (reg4=0x0007) -> reg2=0x1234, reg4=0x0008.
- ZERO_R0=1 instance: load 0xBEEF into reg0, step reg0 -> dbg_data=0x0000; driving reg0 puts 0x0000 on bus.
- Reset mid-operation: assert rst asynchronously between edges while in_en=1, in_sel=1, bus=0x5555 -> reg1=RESET_VAL immediately and remains so after the next edge while rst is high.
